// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte queue between the CPU UART data register and uart_tx.
// The CPU pushes bytes at its own (gated) rate. A small drain FSM hands the
// bytes to uart_tx one at a time over the send/sending handshake.
//
// Ports:
//   clk, n_reset     - system clock, async active-low reset
//   clk_enable       - CPU pipeline enable, qualifies push and clear_overflow
//   wr_valid/wr_data - push request and byte from the store path
//   clear_overflow   - clears the sticky overflow flag
//   full/empty/count - occupancy status, derived from the registered count
//   overflow         - sticky: a push was dropped because the queue was full
//   tx_data/tx_send  - byte and send strobe towards uart_tx
//   tx_sending       - busy flag from uart_tx
module uart_tx_fifo #(
  parameter int unsigned  DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           clk_enable,
  input  logic           wr_valid,
  input  logic [7:0]     wr_data,
  input  logic           clear_overflow,
  output logic           full,
  output logic           empty,
  output logic [PTR_W:0] count,
  output logic           overflow,
  output logic [7:0]     tx_data,
  output logic           tx_send,
  input  logic           tx_sending
);

  localparam int unsigned CNT_W = PTR_W + 1;

  // Pointers wrap by plain overflow, so DEPTH has to be a power of two.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_send_q, tx_send_d;
  logic [7:0]       mem_q [DEPTH];

  logic pop_c;
  logic push_req_c;
  logic push_acc_c;
  logic drop_c;

  // Drain FSM: a pop happens only on the IDLE->LAUNCH transition.
  always_comb begin
    state_d   = state_q;
    pop_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_q && !tx_sending) begin
          pop_c   = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tx_sending) state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!tx_sending) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    tx_send_d = (state_d == LAUNCH);
  end

  // Queue bookkeeping. A pop in the same cycle frees a slot for a push at full;
  // in that case wr_ptr == rd_ptr and the read sees the old byte.
  always_comb begin
    push_req_c = clk_enable & wr_valid;
    push_acc_c = push_req_c & (~full_q | pop_c);
    drop_c     = push_req_c & full_q & ~pop_c;

    wr_ptr_d   = push_acc_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    tx_data_d  = pop_c ? mem_q[rd_ptr_q] : tx_data_q;

    count_d    = count_q + CNT_W'(push_acc_c) - CNT_W'(pop_c);
    full_d     = (count_d == CNT_W'(DEPTH));
    empty_d    = (count_d == '0);

    // A new drop wins over a clear issued in the same cycle.
    overflow_d = drop_c | (overflow_q & ~(clk_enable & clear_overflow));
  end

  // Control and status state.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      tx_send_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
    end
  end

  // Byte storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push_acc_c) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign tx_send  = tx_send_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a push/status vector table, hand sequences for the
// latency, push-at-pop and reset corners, and a randomized burst phase checked
// against a byte-queue reference model. uart_tx is modelled as raising sending
// two cycles after a send and holding it for 20 cycles.
module tb_uart_tx_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       clk_enable = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clear_overflow = 1'b0;
  logic       full, empty, overflow, tx_send, tx_sending;
  logic [4:0] count;
  logic [7:0] tx_data;

  logic       hold_busy = 1'b0;
  logic       model_busy = 1'b0;
  int         dly = 0;
  int         busy_left = 0;
  logic       send_prev = 1'b0;
  logic [7:0] got_q[$];

  int n_checks = 0;
  int n_pass = 0;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .n_reset(n_reset), .clk_enable(clk_enable),
    .wr_valid(wr_valid), .wr_data(wr_data), .clear_overflow(clear_overflow),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .tx_send(tx_send), .tx_sending(tx_sending)
  );

  always #5 clk = ~clk;

  assign tx_sending = model_busy | hold_busy;

  // uart_tx behaviour: sending rises 2 cycles after send, stays high 20 cycles.
  always @(posedge clk) begin
    if (dly != 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        model_busy <= 1'b1;
        busy_left  <= 20;
      end
    end else if (model_busy) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) model_busy <= 1'b0;
    end else if (tx_send) begin
      dly <= 2;
    end
  end

  // Every rising tx_send is one transmitted byte.
  always @(negedge clk) begin
    if (tx_send && !send_prev) got_q.push_back(tx_data);
    send_prev <= tx_send;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic ce, input logic wv, input logic [7:0] d, input logic clr);
    clk_enable     = ce;
    wr_valid       = wv;
    wr_data        = d;
    clear_overflow = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clk_enable     = 1'b0;
    wr_valid       = 1'b0;
    wr_data        = 8'h00;
    clear_overflow = 1'b0;
  endtask

  task automatic wait_launches(input int target, input int budget, input string name);
    int n = 0;
    while (got_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(got_q.size() >= target), 32'd1);
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n = 0;
    while (!(empty && !tx_send && !tx_sending) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(empty && !tx_send && !tx_sending), 32'd1);
  endtask

  task automatic wait_count_le(input int lim, input int budget, input string name);
    int n = 0;
    while (int'(count) > lim && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(int'(count) <= lim), 32'd1);
  endtask

  function automatic logic [31:0] got_at(input int idx);
    if (idx < got_q.size()) return 32'(got_q[idx]);
    return 32'hDEAD;
  endfunction

  typedef struct {
    logic       ce;
    logic       wv;
    logic [7:0] data;
    logic       clr;
    logic [4:0] exp_count;
    logic       exp_full;
    logic       exp_empty;
    logic       exp_ov;
  } vec_t;

  vec_t       vecs[22];
  logic [7:0] exp_q[$];

  initial begin
    int base;
    // Fill to full with the serializer held busy, then overflow/clear corners.
    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 5'(i + 1), (i == 15), 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 8'hCC, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0}; // gated push: no effect
    vecs[17] = '{1'b1, 1'b1, 8'hAA, 1'b0, 5'd16, 1'b1, 1'b0, 1'b1}; // dropped, overflow set
    vecs[18] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1}; // gated clear ignored
    vecs[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0}; // clear
    vecs[20] = '{1'b1, 1'b1, 8'hBB, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1}; // clear + new drop
    vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_tx_send", 32'(tx_send), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte: tx_send at N+2, no fall-through.
    base = got_q.size();
    drive(1'b1, 1'b1, 8'h41, 1'b0);
    idle_inputs();
    check("lat_n1_count", 32'(count), 32'd1);
    check("lat_n1_tx_send", 32'(tx_send), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_n2_tx_send", 32'(tx_send), 32'd1);
    check("lat_n2_tx_data", 32'(tx_data), 32'h41);
    check("lat_n2_count", 32'(count), 32'd0);
    begin
      int n = 0;
      while (!tx_sending && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check("lat_sending_rose", 32'(tx_sending), 32'd1);
    check("lat_send_held", 32'(tx_send), 32'd1);
    @(negedge clk);
    check("lat_send_fell", 32'(tx_send), 32'd0);
    wait_drained(100, "lat_drain");
    check("lat_end_count", 32'(count), 32'd0);
    check("lat_end_empty", 32'(empty), 32'd1);
    check("lat_tx_data_hold", 32'(tx_data), 32'h41);
    check("lat_byte", got_at(base), 32'h41);
    check("lat_nbytes", 32'(got_q.size() - base), 32'd1);

    // Table: fill, overflow and clear corners with the serializer busy.
    repeat (3) @(negedge clk);
    hold_busy = 1'b1;
    base = got_q.size();
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].ce, vecs[i].wv, vecs[i].data, vecs[i].clr);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ov));
    end

    // Push at full in the same cycle as the pop.
    hold_busy = 1'b0;
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    idle_inputs();
    check("pp_count", 32'(count), 32'd16);
    check("pp_full", 32'(full), 32'd1);
    check("pp_overflow", 32'(overflow), 32'd0);
    check("pp_tx_send", 32'(tx_send), 32'd1);
    check("pp_tx_data", 32'(tx_data), 32'h10);
    wait_launches(base + 17, 17 * 40, "fill_launches");
    wait_drained(100, "fill_drain");
    for (int i = 0; i < 16; i++)
      check($sformatf("fill_byte%0d", i), got_at(base + i), 32'(8'h10 + i));
    check("fill_byte_last", got_at(base + 16), 32'h55);
    check("fill_nbytes", 32'(got_q.size() - base), 32'd17);
    check("fill_end_count", 32'(count), 32'd0);

    // Randomized bursts against a byte-queue model; occupancy stays below DEPTH.
    base = got_q.size();
    exp_q.delete();
    for (int b = 0; b < 4; b++) begin
      int acc = 0;
      wait_count_le(4, 400, $sformatf("rnd_room%0d", b));
      while (acc < 10) begin
        logic       ce, wv;
        logic [7:0] d;
        ce = ($urandom_range(0, 3) != 0);
        wv = ($urandom_range(0, 4) != 0);
        d  = 8'($urandom);
        drive(ce, wv, d, 1'b0);
        if (ce && wv) begin
          exp_q.push_back(d);
          acc++;
        end
      end
      idle_inputs();
      repeat ($urandom_range(5, 60)) @(negedge clk);
    end
    wait_launches(base + exp_q.size(), 40 * 40, "rnd_launches");
    wait_drained(100, "rnd_drain");
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rnd_byte%0d", i), got_at(base + i), 32'(exp_q[i]));
    check("rnd_nbytes", 32'(got_q.size() - base), 32'(exp_q.size()));
    check("rnd_overflow", 32'(overflow), 32'd0);
    check("rnd_empty", 32'(empty), 32'd1);

    // Reset while in LAUNCH with 5 bytes still queued.
    repeat (3) @(negedge clk);
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
    idle_inputs();
    hold_busy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_launch", 32'(tx_send), 32'd1);
    check("rst_mid_count", 32'(count), 32'd5);
    n_reset = 1'b0;
    #1;
    check("rst_mid_tx_send", 32'(tx_send), 32'd0);
    check("rst_mid_count0", 32'(count), 32'd0);
    check("rst_mid_empty", 32'(empty), 32'd1);
    check("rst_mid_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    base = got_q.size();
    repeat (40) @(negedge clk);
    check("rst_post_nbytes", 32'(got_q.size() - base), 32'd0);
    check("rst_post_tx_send", 32'(tx_send), 32'd0);
    drive(1'b1, 1'b1, 8'h77, 1'b0);
    idle_inputs();
    wait_launches(base + 1, 50, "rst_post_launch");
    check("rst_post_byte", got_at(base), 32'h77);
    wait_drained(100, "rst_post_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
